itch_msg_buffer: RTL and testbench

ITCH_MSG_BUFFER -- requirements
Module: itch_msg_buffer

---
 rtl/hft_pkg.sv | 30 +++
 rtl/msg_fifo.sv | 66 ++++++
 rtl/itch_msg_buffer.sv | 133 +++++++++++++
 tb/tb_itch_msg_buffer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hft_pkg.sv
// Shared constants and types for the ITCH front end and order-book stages.
package hft_pkg;

    localparam int WORD_BITS = 32;
    localparam int MSG_WORDS = 10;
    localparam int MSG_BITS  = WORD_BITS * MSG_WORDS;

    localparam logic [7:0] MSG_TYPE_ADD     = 8'h41;
    localparam logic [7:0] MSG_TYPE_DELETE  = 8'h44;
    localparam logic [7:0] MSG_TYPE_EXEC    = 8'h45;
    localparam logic [7:0] MSG_TYPE_SYSTEM  = 8'h53;
    localparam logic [7:0] MSG_TYPE_REPLACE = 8'h55;

    typedef logic [MSG_BITS-1:0] msg_t;

    typedef enum logic {
        ST_ASSEMBLE = 1'b0,
        ST_DISCARD  = 1'b1
    } asm_state_e;

    function automatic logic msg_type_known(input logic [7:0] msg_type);
        return msg_type inside {MSG_TYPE_ADD, MSG_TYPE_DELETE, MSG_TYPE_EXEC,
                                MSG_TYPE_SYSTEM, MSG_TYPE_REPLACE};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// DEPTH-entry message FIFO with a registered head that holds its last value when empty.
module msg_fifo
    import hft_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  msg_t push_data,
    input  logic pop,
    output msg_t head,
    output logic not_empty,
    output logic full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    msg_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_pop;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;

    assign full            = (count == DEPTH_C);
    assign not_empty       = (count != '0);
    assign do_push         = push && !full;
    assign do_pop          = pop && not_empty;
    assign rd_next         = rd_ptr + AW'(do_pop);
    assign count_after_pop = count - CW'(do_pop);
    assign count_next      = count_after_pop + CW'(do_push);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_next;
            count  <= count_next;
            // A push landing in an otherwise empty FIFO is not yet in mem, so bypass it.
            if (count_next != '0) begin
                if (do_push && (count_after_pop == '0)) begin
                    head <= push_data;
                end else begin
                    head <= mem[rd_next];
                end
            end
        end
    end

endmodule

// File: rtl/itch_msg_buffer.sv
// Assembles 10-word ITCH messages into a FIFO and pops on system_free rising edges.
// Optional type filtering is enabled by defining MSG_TYPE_FILTER_EN.
//
// state       | meaning
// ST_ASSEMBLE | collecting words 0..9 of a message
// ST_DISCARD  | word 9 arrived without in_last; dropping words through next in_last
module itch_msg_buffer
    import hft_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    input  logic [31:0]         in_data,
    input  logic                in_last,
    output logic                in_ready,
    input  logic                system_free,
    output logic                buffer_not_empty,
    output logic [MSG_BITS-1:0] ff_buffer,
    output logic [15:0]         err_count,
    output logic [15:0]         drop_count
);

    localparam int         ASM_BITS = MSG_BITS - WORD_BITS;
    localparam logic [3:0] LAST_IDX = 4'(MSG_WORDS - 1);

    asm_state_e          state_q;
    asm_state_e          state_d;
    logic [3:0]          idx_q;
    logic [3:0]          idx_d;
    logic [ASM_BITS-1:0] asm_q;
    logic [ASM_BITS-1:0] asm_d;
    logic [15:0]         err_q;
    logic [15:0]         err_d;
    logic                sf_q;
    logic                accept;
    logic                msg_done;
    logic                type_ok;
    logic                commit;
    logic                pop;
    logic                fifo_full;
    msg_t                msg_word;

    assign in_ready  = !fifo_full;
    assign accept    = in_valid && in_ready;
    assign msg_word  = {asm_q, in_data};
    assign commit    = msg_done && type_ok;
    assign pop       = system_free && !sf_q;
    assign err_count = err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_ASSEMBLE;
            idx_q   <= '0;
            asm_q   <= '0;
            err_q   <= '0;
            sf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
            sf_q    <= system_free;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        asm_d    = asm_q;
        err_d    = err_q;
        msg_done = 1'b0;
        if (accept) begin
            case (state_q)
                ST_ASSEMBLE: begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (in_last) begin
                            msg_done = 1'b1;
                        end else begin
                            err_d   = sat_inc16(err_q);
                            state_d = ST_DISCARD;
                        end
                    end else if (in_last) begin
                        idx_d = '0;
                        err_d = sat_inc16(err_q);
                    end else begin
                        // Shifting keeps word 0 at the top once all ten words are in.
                        idx_d = idx_q + 4'd1;
                        asm_d = {asm_q[ASM_BITS-WORD_BITS-1:0], in_data};
                    end
                end
                ST_DISCARD: begin
                    if (in_last) begin
                        state_d = ST_ASSEMBLE;
                    end
                end
                default: state_d = ST_ASSEMBLE;
            endcase
        end
    end

`ifdef MSG_TYPE_FILTER_EN
    logic [15:0] drop_q;

    assign type_ok    = msg_type_known(msg_word[MSG_BITS-1 -: 8]);
    assign drop_count = drop_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_q <= '0;
        end else if (msg_done && !type_ok) begin
            drop_q <= sat_inc16(drop_q);
        end
    end
`else
    assign type_ok    = 1'b1;
    assign drop_count = '0;
`endif

    msg_fifo #(.DEPTH(DEPTH)) u_msg_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (commit),
        .push_data (msg_word),
        .pop       (pop),
        .head      (ff_buffer),
        .not_empty (buffer_not_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_itch_msg_buffer.sv
// Scoreboard bench for itch_msg_buffer: message-level reference model, monitor checks every cycle.
module tb_itch_msg_buffer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic         system_free = 1'b0;
    logic         buffer_not_empty;
    logic [319:0] ff_buffer;
    logic [15:0]  err_count;
    logic [15:0]  drop_count;

    int checks = 0;
    int errors = 0;

    logic [319:0] exp_q [$];
    logic [319:0] last_head = '0;
    int           exp_err = 0;
    int           exp_drop = 0;
    logic         mon_prev = 1'b0;
    logic         rand_gaps = 1'b0;

    always #5 clk = ~clk;

    itch_msg_buffer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .system_free      (system_free),
        .buffer_not_empty (buffer_not_empty),
        .ff_buffer        (ff_buffer),
        .err_count        (err_count),
        .drop_count       (drop_count)
    );

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic type_pass(input logic [7:0] t);
`ifdef MSG_TYPE_FILTER_EN
        return (t == 8'h41) || (t == 8'h44) || (t == 8'h45) || (t == 8'h53) || (t == 8'h55);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [319:0] rand_msg(input logic [7:0] t);
        logic [319:0] m;
        for (int i = 0; i < 10; i++) m[319-32*i -: 32] = $urandom;
        m[319:312] = t;
        return m;
    endfunction

    // Monitor: DUT state after each rising edge is compared to the model at the falling edge.
    always @(negedge clk) begin
        check("in_ready", {319'd0, in_ready}, {319'd0, exp_q.size() < DEPTH});
        check("not_empty", {319'd0, buffer_not_empty}, {319'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) last_head = exp_q[0];
        check("ff_buffer", ff_buffer, last_head);
        check("err_count", {304'd0, err_count}, 320'(exp_err));
        check("drop_count", {304'd0, drop_count}, 320'(exp_drop));
        if (!resetn) begin
            mon_prev = 1'b0;
        end else begin
            if (system_free && !mon_prev && exp_q.size() != 0) void'(exp_q.pop_front());
            mon_prev = system_free;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        logic ok;
        int   budget;
        ok = 1'b0;
        budget = 200;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!ok && budget > 0) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            budget--;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles, required 1");
        end
    endtask

    // kind 0: well-formed; 1: in_last on word pos; 2: no in_last on word 9, then pos tail words
    task automatic send_msg(input logic [319:0] m, input int kind, input int pos);
        int n;
        n = (kind == 1) ? pos + 1 : 10;
        for (int i = 0; i < n; i++) begin
            if (rand_gaps && $urandom_range(0, 3) == 0) tick();
            send_word(m[319-32*i -: 32], (kind == 0 && i == 9) || (kind == 1 && i == pos));
        end
        if (kind == 0) begin
            if (type_pass(m[319:312])) exp_q.push_back(m);
            else if (exp_drop < 65535) exp_drop++;
        end else begin
            if (exp_err < 65535) exp_err++;
        end
        if (kind == 2) begin
            for (int j = 0; j < pos; j++) send_word($urandom, j == pos - 1);
        end
    endtask

    task automatic pulse_free();
        system_free = 1'b1;
        tick();
        system_free = 1'b0;
        tick();
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 3 * DEPTH) begin
            pulse_free();
            b++;
        end
    endtask

    task automatic sample_check(input string name, input logic act, input logic req);
        @(negedge clk);
        check(name, {319'd0, act}, {319'd0, req});
        tick();
    endtask

    logic [319:0] msg;
    logic [7:0]   types [6] = '{8'h41, 8'h44, 8'h45, 8'h53, 8'h55, 8'h5A};

    initial begin
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // First message lands at the head the cycle after its last word
        msg = rand_msg(8'h53);
        msg[319:288] = 32'h53785634;
        send_msg(msg, 0, 0);
        @(negedge clk);
        check("t29_not_empty", {319'd0, buffer_not_empty}, 320'd1);
        check("t29_word0", {288'd0, ff_buffer[319:288]}, {288'd0, 32'h53785634});
        tick();
        drain();

        // Fill to DEPTH, back-pressure, one pop frees a slot
        for (int i = 0; i < DEPTH; i++) send_msg(rand_msg(types[i % 5]), 0, 0);
        sample_check("t30_full_ready", in_ready, 1'b0);
        pulse_free();
        sample_check("t30_after_pop_ready", in_ready, 1'b1);
        send_msg(rand_msg(8'h41), 0, 0);
        sample_check("t30_refull_ready", in_ready, 1'b0);
        drain();

        // Early in_last on word 4, then an intact message
        send_msg(rand_msg(8'h45), 1, 4);
        sample_check("t31_no_commit", buffer_not_empty, 1'b0);
        send_msg(rand_msg(8'h44), 0, 0);
        drain();

        // Missing in_last on word 9, tail discarded
        send_msg(rand_msg(8'h41), 2, 3);
        send_msg(rand_msg(8'h55), 0, 0);
        drain();

        // Held-high system_free pops exactly once
        for (int i = 0; i < 3; i++) send_msg(rand_msg(8'h53), 0, 0);
        system_free = 1'b1;
        repeat (5) tick();
        system_free = 1'b0;
        tick();
        sample_check("t32_still_two", buffer_not_empty, 1'b1);
        pulse_free();
        sample_check("t32_one_left", buffer_not_empty, 1'b1);
        pulse_free();
        sample_check("t32_empty", buffer_not_empty, 1'b0);

        // Unknown message type
        send_msg(rand_msg(8'h5A), 0, 0);
`ifdef MSG_TYPE_FILTER_EN
        sample_check("t33_filtered", buffer_not_empty, 1'b0);
`else
        sample_check("t33_committed", buffer_not_empty, 1'b1);
`endif
        drain();

        // Reset mid-message with two stored entries
        send_msg(rand_msg(8'h41), 0, 0);
        send_msg(rand_msg(8'h44), 0, 0);
        msg = rand_msg(8'h45);
        for (int i = 0; i < 7; i++) send_word(msg[319-32*i -: 32], 1'b0);
        resetn = 1'b0;
        exp_q.delete();
        last_head = '0;
        exp_err = 0;
        exp_drop = 0;
        sample_check("t34_ready_in_reset", in_ready, 1'b1);
        resetn = 1'b1;
        tick();
        send_msg(rand_msg(8'h55), 0, 0);
        pulse_free();
        sample_check("t34_only_entry", buffer_not_empty, 1'b0);

        // Randomized traffic
        rand_gaps = 1'b1;
        repeat (60) begin
            int k;
            if (exp_q.size() >= DEPTH) pulse_free();
            k = $urandom_range(0, 4);
            msg = rand_msg(($urandom_range(0, 7) == 0) ? 8'($urandom) : types[$urandom_range(0, 5)]);
            if (k <= 2) send_msg(msg, 0, 0);
            else if (k == 3) send_msg(msg, 1, $urandom_range(0, 8));
            else send_msg(msg, 2, $urandom_range(1, 4));
            if ($urandom_range(0, 2) == 0) pulse_free();
        end
        drain();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached without finishing, required finish");
        $fatal(1);
    end

endmodule
